// File: rtl/vram_sequencer.sv
// Video RAM sequencer: splits each 1 us (16 CLOCK) slot into a two-byte CRTC display
// fetch plus two shared access slots for the Z80 and the auxiliary loader port.
module vram_sequencer (
  input  logic        CLOCK,
  input  logic        nRESET,
  output logic        crtc_ce_o,
  input  logic [13:0] crtc_ma_i,
  input  logic [4:0]  crtc_ra_i,
  output logic [15:0] vid_data_o,
  output logic        vid_valid_o,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_wdata_i,
  output logic [7:0]  cpu_rdata_o,
  output logic        cpu_ack_o,
  output logic        cpu_wait_n_o,
  input  logic        aux_req_i,
  input  logic        aux_we_i,
  input  logic [15:0] aux_addr_i,
  input  logic [7:0]  aux_wdata_i,
  output logic [7:0]  aux_rdata_o,
  output logic        aux_ack_o,
  output logic [15:0] mem_addr_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic [7:0]  mem_d_o,
  input  logic [7:0]  mem_q_i
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_AUX} owner_t;

  logic [3:0]  phase_q, phase_d;
  owner_t      owner_a_q, owner_b_q;
  owner_t      grant_d, done_owner;
  logic        slot_we_q;
  logic [7:0]  byte0_q;
  logic        crtc_ce_q, vid_valid_q;
  logic [15:0] vid_data_q;
  logic [7:0]  cpu_rdata_q, aux_rdata_q;
  logic        cpu_ack_q, aux_ack_q;
  logic [15:0] mem_addr_q;
  logic        mem_rd_q, mem_wr_q;
  logic [7:0]  mem_d_q;

  logic        sel_we;
  logic [15:0] sel_addr;
  logic [7:0]  sel_wdata;
  logic [14:0] vid_base;
  logic        unused_bits;

  // MA[11:10] and RA[4:3] do not take part in the 64 KB screen mapping.
  assign vid_base    = {crtc_ma_i[13:12], crtc_ra_i[2:0], crtc_ma_i[9:0]};
  assign unused_bits = ^{crtc_ma_i[11:10], crtc_ra_i[4:3]};

  always_comb begin
    phase_d    = phase_q + 4'd1;
    grant_d    = OWN_NONE;
    done_owner = OWN_NONE;
    if (phase_q == 4'd7) begin
      if (cpu_req_i)      grant_d = OWN_CPU;
      else if (aux_req_i) grant_d = OWN_AUX;
    end else if (phase_q == 4'd11 && aux_req_i && owner_a_q != OWN_AUX) begin
      // Slot B is aux-only and never repeats an access already served in slot A.
      grant_d = OWN_AUX;
    end
    if (phase_q == 4'd9)       done_owner = owner_a_q;
    else if (phase_q == 4'd13) done_owner = owner_b_q;
    sel_we    = (grant_d == OWN_CPU) ? cpu_we_i    : aux_we_i;
    sel_addr  = (grant_d == OWN_CPU) ? cpu_addr_i  : aux_addr_i;
    sel_wdata = (grant_d == OWN_CPU) ? cpu_wdata_i : aux_wdata_i;
  end

  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      phase_q     <= 4'd0;
      owner_a_q   <= OWN_NONE;
      owner_b_q   <= OWN_NONE;
      slot_we_q   <= 1'b0;
      byte0_q     <= 8'd0;
      crtc_ce_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= 16'd0;
      cpu_rdata_q <= 8'd0;
      aux_rdata_q <= 8'd0;
      cpu_ack_q   <= 1'b0;
      aux_ack_q   <= 1'b0;
      mem_addr_q  <= 16'd0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_d_q     <= 8'd0;
    end else begin
      phase_q     <= phase_d;
      crtc_ce_q   <= (phase_d == 4'd15);
      vid_valid_q <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      aux_ack_q   <= 1'b0;
      // Outputs are registered, so each action is set up on the edge leaving the previous phase.
      case (phase_q)
        4'd1: begin
          mem_rd_q   <= 1'b1;
          mem_addr_q <= {vid_base, 1'b0};
        end
        4'd3: begin
          byte0_q    <= mem_q_i;
          mem_rd_q   <= 1'b1;
          mem_addr_q <= {vid_base, 1'b1};
        end
        4'd5: begin
          vid_data_q  <= {mem_q_i, byte0_q};
          vid_valid_q <= 1'b1;
        end
        4'd7:    owner_a_q <= grant_d;
        4'd11:   owner_b_q <= grant_d;
        default: ;
      endcase
      if (grant_d != OWN_NONE) begin
        mem_addr_q <= sel_addr;
        mem_rd_q   <= ~sel_we;
        mem_wr_q   <= sel_we;
        slot_we_q  <= sel_we;
        if (sel_we) mem_d_q <= sel_wdata;
      end
      if (done_owner == OWN_CPU) begin
        cpu_ack_q <= 1'b1;
        if (!slot_we_q) cpu_rdata_q <= mem_q_i;
      end
      if (done_owner == OWN_AUX) begin
        aux_ack_q <= 1'b1;
        if (!slot_we_q) aux_rdata_q <= mem_q_i;
      end
    end
  end

  assign crtc_ce_o    = crtc_ce_q;
  assign vid_data_o   = vid_data_q;
  assign vid_valid_o  = vid_valid_q;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign cpu_ack_o    = cpu_ack_q;
  assign cpu_wait_n_o = ~(cpu_req_i & ~cpu_ack_q);
  assign aux_rdata_o  = aux_rdata_q;
  assign aux_ack_o    = aux_ack_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_rd_o     = mem_rd_q;
  assign mem_wr_o     = mem_wr_q;
  assign mem_d_o      = mem_d_q;

endmodule

// File: tb/tb_vram_sequencer.sv
// Self-checking bench for vram_sequencer: a RAM device model plus a slot-arithmetic
// reference for display fetch, grant timing, strobes, acks and wait.
module tb_vram_sequencer;

  logic        CLOCK = 1'b0;
  logic        nRESET = 1'b0;
  logic        crtc_ce;
  logic [13:0] crtc_ma = 14'd0;
  logic [4:0]  crtc_ra = 5'd0;
  logic [15:0] vid_data;
  logic        vid_valid;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'd0;
  logic [7:0]  cpu_wdata = 8'd0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack, cpu_wait_n;
  logic        aux_req = 1'b0, aux_we = 1'b0;
  logic [15:0] aux_addr = 16'd0;
  logic [7:0]  aux_wdata = 8'd0;
  logic [7:0]  aux_rdata;
  logic        aux_ack;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_d;
  logic [7:0]  mem_q = 8'd0;

  int total = 0;
  int bad = 0;

  always #5 CLOCK = ~CLOCK;

  vram_sequencer dut (
    .CLOCK(CLOCK), .nRESET(nRESET),
    .crtc_ce_o(crtc_ce), .crtc_ma_i(crtc_ma), .crtc_ra_i(crtc_ra),
    .vid_data_o(vid_data), .vid_valid_o(vid_valid),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack), .cpu_wait_n_o(cpu_wait_n),
    .aux_req_i(aux_req), .aux_we_i(aux_we), .aux_addr_i(aux_addr), .aux_wdata_i(aux_wdata),
    .aux_rdata_o(aux_rdata), .aux_ack_o(aux_ack),
    .mem_addr_o(mem_addr), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .mem_d_o(mem_d),
    .mem_q_i(mem_q)
  );

  // 64 KB RAM device with one-cycle read latency and a bench-side preload port.
  logic [7:0]  ram [0:65535];
  logic        filled = 1'b0;
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'd0;
  logic [7:0]  pre_data = 8'd0;

  always @(posedge CLOCK) begin
    if (!filled) begin
      for (int i = 0; i < 65536; i++) ram[i] <= 8'($urandom);
      filled <= 1'b1;
    end else begin
      if (pre_we) ram[pre_addr] <= pre_data;
      if (mem_wr) ram[mem_addr] <= mem_d;
    end
    if (mem_rd) mem_q <= ram[mem_addr];
  end

  // Slot phase as the bench understands it: zero in reset, +1 per clock otherwise.
  logic [3:0] model_phase = 4'd0;
  always @(posedge CLOCK) model_phase <= nRESET ? model_phase + 4'd1 : 4'd0;

  task automatic step();
    @(negedge CLOCK);
    #1;
  endtask

  task automatic goto_phase(input int p);
    step();
    while (model_phase != 4'(p)) step();
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    step();
    pre_we   = 1'b0;
  endtask

  task automatic test_reset();
    nRESET  = 1'b0;
    cpu_req = 1'b1;
    repeat (3) step();
    total++;
    if ({crtc_ce, vid_valid, cpu_ack, aux_ack, mem_rd, mem_wr} !== 6'b0) begin
      bad++;
      $display("FAIL reset_strobes got=%b want=000000",
               {crtc_ce, vid_valid, cpu_ack, aux_ack, mem_rd, mem_wr});
    end
    total++;
    if ({vid_data, cpu_rdata, aux_rdata, mem_addr, mem_d} !== 56'd0) begin
      bad++;
      $display("FAIL reset_data got vid=%h crd=%h ard=%h addr=%h d=%h want all zero",
               vid_data, cpu_rdata, aux_rdata, mem_addr, mem_d);
    end
    total++;
    if (cpu_wait_n !== 1'b0) begin
      bad++;
      $display("FAIL reset_wait_req got=%b want=0", cpu_wait_n);
    end
    cpu_req = 1'b0;
    #1;
    total++;
    if (cpu_wait_n !== 1'b1) begin
      bad++;
      $display("FAIL reset_wait_idle got=%b want=1", cpu_wait_n);
    end
    nRESET = 1'b1;
    $display("txn reset: done");
  endtask

  task automatic test_free_run();
    logic [3:0] exp;
    int ph;
    goto_phase(0);
    for (int k = 0; k < 48; k++) begin
      ph  = (k % 16);
      exp = {ph == 15, ph == 6, (ph == 2 || ph == 4), 1'b0};
      total++;
      if ({crtc_ce, vid_valid, mem_rd, mem_wr} !== exp) begin
        bad++;
        $display("FAIL free_run phase=%0d got ce/vv/rd/wr=%b want %b",
                 ph, {crtc_ce, vid_valid, mem_rd, mem_wr}, exp);
      end
      step();
    end
    $display("txn free_run: 48 cycles");
  endtask

  task automatic test_video();
    logic [13:0] ma;
    logic [4:0]  ra;
    logic [15:0] a0, a1, exp_d;
    for (int i = 0; i < 6; i++) begin
      ma = (i == 0) ? 14'h3005 : 14'($urandom);
      ra = (i == 0) ? 5'd2 : 5'($urandom);
      a0 = {ma[13:12], ra[2:0], ma[9:0], 1'b0};
      a1 = {ma[13:12], ra[2:0], ma[9:0], 1'b1};
      if (i == 0) begin
        preload(a0, 8'h11);
        preload(a1, 8'h22);
      end
      goto_phase(0);
      crtc_ma = ma;
      crtc_ra = ra;
      exp_d = (i == 0) ? 16'h2211 : {ram[a1], ram[a0]};
      goto_phase(2);
      total++;
      if (mem_rd !== 1'b1 || mem_addr !== a0) begin
        bad++;
        $display("FAIL video_byte0 rd=%b addr=%h want rd=1 addr=%h", mem_rd, mem_addr, a0);
      end
      goto_phase(4);
      total++;
      if (mem_rd !== 1'b1 || mem_addr !== a1) begin
        bad++;
        $display("FAIL video_byte1 rd=%b addr=%h want rd=1 addr=%h", mem_rd, mem_addr, a1);
      end
      goto_phase(6);
      total++;
      if (vid_valid !== 1'b1 || vid_data !== exp_d) begin
        bad++;
        $display("FAIL video_data valid=%b data=%h want valid=1 data=%h", vid_valid, vid_data, exp_d);
      end
      $display("txn video ma=%h ra=%0d addr=%h data=%h", ma, ra, a0, exp_d);
    end
  endtask

  // Requests raised at phase p are granted at the next grant edge the rules allow,
  // strobed one cycle later and acknowledged three cycles after the grant edge.
  task automatic run_txn(input bit uc, input bit cwe, input logic [15:0] ca, input logic [7:0] cd,
                         input bit ua, input bit awe, input logic [15:0] aa, input logic [7:0] ad,
                         input int p, input int ahold, input string tag);
    int cg, ag, cack, aack, last, ph;
    logic [7:0] crd, ard;
    bit exp_rd, exp_wr;
    cg = -100;
    ag = -100;
    if (uc) cg = (7 - p + 16) % 16;
    if (ua) begin
      for (int k = 0; k < 32; k++) begin
        ph = (p + k) % 16;
        if ((ph == 7 && !(uc && k <= cg)) || ph == 11) begin
          ag = k;
          break;
        end
      end
    end
    cack = cg + 3;
    aack = ag + 3;
    last = ((cack > aack + ahold) ? cack : aack + ahold) + 4;
    goto_phase(p);
    crd = ram[ca];
    ard = ram[aa];
    cpu_we = cwe; cpu_addr = ca; cpu_wdata = cd; cpu_req = uc;
    aux_we = awe; aux_addr = aa; aux_wdata = ad; aux_req = ua;
    #1;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) step();
      ph = (p + k) % 16;
      exp_rd = (ph == 2 || ph == 4) || (uc && k == cg + 1 && !cwe) || (ua && k == ag + 1 && !awe);
      exp_wr = (uc && k == cg + 1 && cwe) || (ua && k == ag + 1 && awe);
      total++;
      if ({mem_rd, mem_wr} !== {exp_rd, exp_wr}) begin
        bad++;
        $display("FAIL %s strobe k=%0d phase=%0d got rd/wr=%b%b want %b%b",
                 tag, k, ph, mem_rd, mem_wr, exp_rd, exp_wr);
      end
      if (uc && k == cg + 1) begin
        total++;
        if (mem_addr !== ca || (cwe && mem_d !== cd)) begin
          bad++;
          $display("FAIL %s cpu_bus addr=%h d=%h want addr=%h d=%h", tag, mem_addr, mem_d, ca, cd);
        end
      end
      if (ua && k == ag + 1) begin
        total++;
        if (mem_addr !== aa || (awe && mem_d !== ad)) begin
          bad++;
          $display("FAIL %s aux_bus addr=%h d=%h want addr=%h d=%h", tag, mem_addr, mem_d, aa, ad);
        end
      end
      total++;
      if (cpu_ack !== (uc && k == cack)) begin
        bad++;
        $display("FAIL %s cpu_ack k=%0d phase=%0d got=%b want=%b", tag, k, ph, cpu_ack, (uc && k == cack));
      end
      total++;
      if (aux_ack !== (ua && k == aack)) begin
        bad++;
        $display("FAIL %s aux_ack k=%0d phase=%0d got=%b want=%b", tag, k, ph, aux_ack, (ua && k == aack));
      end
      total++;
      if (cpu_wait_n !== !(uc && k < cack)) begin
        bad++;
        $display("FAIL %s cpu_wait_n k=%0d phase=%0d got=%b want=%b", tag, k, ph, cpu_wait_n, !(uc && k < cack));
      end
      if (uc && k == cack) begin
        total++;
        if (!cwe && cpu_rdata !== crd) begin
          bad++;
          $display("FAIL %s cpu_rdata got=%h want=%h", tag, cpu_rdata, crd);
        end else if (cwe && ram[ca] !== cd) begin
          bad++;
          $display("FAIL %s cpu_write ram[%h]=%h want=%h", tag, ca, ram[ca], cd);
        end
        cpu_req = 1'b0;
      end
      if (ua && k == aack) begin
        total++;
        if (!awe && aux_rdata !== ard) begin
          bad++;
          $display("FAIL %s aux_rdata got=%h want=%h", tag, aux_rdata, ard);
        end else if (awe && ram[aa] !== ad) begin
          bad++;
          $display("FAIL %s aux_write ram[%h]=%h want=%h", tag, aa, ram[aa], ad);
        end
      end
      if (ua && k == aack + ahold) aux_req = 1'b0;
    end
    $display("txn %s p=%0d cpu=%0d we=%0d addr=%h aux=%0d we=%0d addr=%h cpu_ack@%0d aux_ack@%0d",
             tag, p, uc, cwe, ca, ua, awe, aa, uc ? cack : -1, ua ? aack : -1);
  endtask

  task automatic test_cpu_write_read();
    run_txn(1'b1, 1'b1, 16'h4000, 8'h5A, 1'b0, 1'b0, 16'h0, 8'h0, 3, 0, "cpu_write");
    run_txn(1'b1, 1'b0, 16'h4000, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, 2, 0, "cpu_readback");
    total++;
    if (cpu_rdata !== 8'h5A) begin
      bad++;
      $display("FAIL cpu_readback_value got=%h want=5a", cpu_rdata);
    end
  endtask

  task automatic test_cpu_late();
    run_txn(1'b1, 1'b0, 16'(16'h1234), 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, 9, 0, "cpu_late");
  endtask

  task automatic test_both_same_phase();
    run_txn(1'b1, 1'b1, 16'h2222, 8'hC3, 1'b1, 1'b0, 16'h3333, 8'h0, 5, 0, "both_p5");
  endtask

  task automatic test_aux_alone();
    run_txn(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b1, 16'h5555, 8'hA7, 5, 2, "aux_alone");
  endtask

  task automatic test_reset_mid_slot();
    logic [7:0] crd;
    goto_phase(5);
    crd = ram[16'h6001];
    cpu_we = 1'b0; cpu_addr = 16'h6001; cpu_req = 1'b1;
    goto_phase(9);
    nRESET = 1'b0;
    step();
    total++;
    if (cpu_ack !== 1'b0 || mem_rd !== 1'b0 || cpu_wait_n !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid ack=%b rd=%b wait_n=%b want 0 0 0", cpu_ack, mem_rd, cpu_wait_n);
    end
    nRESET = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      total++;
      if (cpu_ack !== (k == 10) || cpu_wait_n !== !(k < 10)) begin
        bad++;
        $display("FAIL reset_mid_regrant k=%0d ack=%b wait_n=%b want %b %b",
                 k, cpu_ack, cpu_wait_n, (k == 10), !(k < 10));
      end
      if (k == 10) begin
        total++;
        if (cpu_rdata !== crd) begin
          bad++;
          $display("FAIL reset_mid_rdata got=%h want=%h", cpu_rdata, crd);
        end
        cpu_req = 1'b0;
      end
    end
    $display("txn reset_mid_slot: regranted read of 6001");
  endtask

  task automatic test_back_to_back();
    bit uc, ua;
    logic [15:0] ca, aa;
    for (int i = 0; i < 30; i++) begin
      uc = 1'($urandom);
      ua = 1'($urandom);
      if (!uc && !ua) uc = 1'b1;
      ca = 16'($urandom);
      aa = 16'($urandom);
      if (aa == ca) aa = ca ^ 16'h0100;
      run_txn(uc, 1'($urandom), ca, 8'($urandom), ua, 1'($urandom), aa, 8'($urandom),
              int'($urandom_range(0, 15)), 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_video();
    test_cpu_write_read();
    test_cpu_late();
    test_both_same_phase();
    test_aux_alone();
    test_reset_mid_slot();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
